scan_group_bridge: RTL and testbench

SCAN_GROUP_BRIDGE -- requirements
Module: scan_group_bridge

---
 rtl/scan_bridge_pkg.sv | 17 +
 rtl/scan_req_sync.sv | 51 +++++
 rtl/scan_group_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_scan_group_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_bridge_pkg.sv
// Shared definitions for the scan-to-group bridge.
// Holds the bridge FSM state encoding and the bit positions of static_status.
package scan_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } bridge_state_e;

  // static_status = {err_id, err_conflict, err_timeout}
  localparam int unsigned STAT_TIMEOUT  = 0;
  localparam int unsigned STAT_CONFLICT = 1;
  localparam int unsigned STAT_ID       = 2;

endpackage

// File: rtl/scan_req_sync.sv
// Two-flop synchroniser with rising-edge detect for one scan request level.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req_in     - asynchronous request level from the scan side
//   req_level  - synchronised level
//   req_rise_c - one-cycle pulse on a synchronised 0->1 transition
// A level already high when reset is released never produces a pulse: the
// detector only arms once it has seen the synchronised level low.
module scan_req_sync (
  input  logic clk,
  input  logic rst,
  input  logic req_in,
  output logic req_level,
  output logic req_rise_c
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic       armed_q, armed_d;
  logic [1:0] settle_q, settle_d;

  // settle_q[1] marks that sync2_q now holds a genuinely sampled value
  always_comb begin
    sync1_d  = req_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    settle_d = {settle_q[0], 1'b1};
    armed_d  = armed_q | (settle_q[1] & ~sync2_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
      settle_q <= 2'b00;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      armed_q  <= armed_d;
      settle_q <= settle_d;
    end
  end

  assign req_level  = sync2_q;
  assign req_rise_c = armed_q & sync2_q & ~prev_q;

endmodule

// File: rtl/scan_group_bridge.sv
// Bridge from a slow scan-side static register interface to N target groups.
// A synchronised rising edge on static_wen/static_ren launches one read or
// write (or a write fill burst) toward group scan_id with a ready handshake.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   scan_id, static_*           - scan-side request, address, data, fill count
//   static_rdata                - data captured from the last read
//   static_ready                - high when idle or finished
//   static_status               - sticky {err_id, err_conflict, err_timeout}
//   grp_wen, grp_ren            - per-group strobes (at most one high)
//   grp_addr, grp_wdata         - shared group address / write data
//   grp_rdata, grp_ready        - per-group read data and ready
module scan_group_bridge
  import scan_bridge_pkg::*;
#(
  parameter int unsigned N_GROUPS = 4,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 255,
  localparam int unsigned ID_W    = $clog2(N_GROUPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_W-1:0]            scan_id,
  input  logic                       static_wen,
  input  logic                       static_ren,
  input  logic [ADDR_W-1:0]          static_addr,
  input  logic [DATA_W-1:0]          static_wdata,
  input  logic [CNT_W-1:0]           static_fill_cnt,
  output logic [DATA_W-1:0]          static_rdata,
  output logic                       static_ready,
  output logic [2:0]                 static_status,
  output logic [N_GROUPS-1:0]        grp_wen,
  output logic [N_GROUPS-1:0]        grp_ren,
  output logic [ADDR_W-1:0]          grp_addr,
  output logic [DATA_W-1:0]          grp_wdata,
  input  logic [N_GROUPS*DATA_W-1:0] grp_rdata,
  input  logic [N_GROUPS-1:0]        grp_ready
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic wen_level, wen_rise_c;
  logic ren_level, ren_rise_c;

  scan_req_sync u_wen_sync (
    .clk        (clk),
    .rst        (rst),
    .req_in     (static_wen),
    .req_level  (wen_level),
    .req_rise_c (wen_rise_c)
  );

  scan_req_sync u_ren_sync (
    .clk        (clk),
    .rst        (rst),
    .req_in     (static_ren),
    .req_level  (ren_level),
    .req_rise_c (ren_rise_c)
  );

  bridge_state_e       state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [TO_W-1:0]     wcnt_q, wcnt_d;
  logic [N_GROUPS-1:0] grp_wen_q, grp_wen_d;
  logic [N_GROUPS-1:0] grp_ren_q, grp_ren_d;
  logic [ADDR_W-1:0]   grp_addr_q, grp_addr_d;
  logic [DATA_W-1:0]   grp_wdata_q, grp_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          status_q, status_d;
  logic                ready_q, ready_d;

  logic [N_GROUPS-1:0] strobe_mask;
  logic [DATA_W-1:0]   rdata_sel;
  logic                ready_sel;
  logic                id_valid;
  logic                last_word;

  // Per-group selection of the latched target
  always_comb begin
    rdata_sel = '0;
    ready_sel = 1'b0;
    for (int unsigned g = 0; g < N_GROUPS; g++) begin
      if (id_q == ID_W'(g)) begin
        rdata_sel = grp_rdata[g*DATA_W +: DATA_W];
        ready_sel = grp_ready[g];
      end
    end
  end

  assign strobe_mask = N_GROUPS'(1) << id_q;
  assign id_valid    = 32'(scan_id) < N_GROUPS;
  assign last_word   = rem_q <= CNT_W'(1);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    rem_d       = rem_q;
    wcnt_d      = wcnt_q;
    grp_wen_d   = '0;
    grp_ren_d   = '0;
    grp_addr_d  = grp_addr_q;
    grp_wdata_d = grp_wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;

    unique case (state_q)
      IDLE: begin
        if (wen_rise_c && ren_rise_c) begin
          status_d                = '0;
          status_d[STAT_CONFLICT] = 1'b1;
          state_d                 = DONE;
        end else if (wen_rise_c || ren_rise_c) begin
          status_d = '0;
          if (!id_valid) begin
            status_d[STAT_ID] = 1'b1;
            state_d           = DONE;
          end else begin
            id_d    = scan_id;
            addr_d  = static_addr;
            wdata_d = static_wdata;
            rd_d    = ren_rise_c;
            // Only writes with a count of two or more become a fill burst
            rem_d   = (wen_rise_c && (static_fill_cnt >= CNT_W'(2)))
                      ? static_fill_cnt : CNT_W'(1);
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (rd_q) grp_ren_d = strobe_mask;
        else      grp_wen_d = strobe_mask;
        grp_addr_d  = addr_q;
        grp_wdata_d = wdata_q;
        wcnt_d      = '0;
        state_d     = WAIT;
      end

      WAIT: begin
        if (ready_sel) begin
          if (rd_q) rdata_d = rdata_sel;
          if (!last_word) begin
            rem_d   = rem_q - CNT_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
          status_d[STAT_TIMEOUT] = 1'b1;
          state_d                = DONE;
        end else begin
          grp_wen_d = grp_wen_q;
          grp_ren_d = grp_ren_q;
          wcnt_d    = wcnt_q + TO_W'(1);
        end
      end

      DONE: begin
        if (!wen_level && !ren_level) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      rem_q       <= '0;
      wcnt_q      <= '0;
      grp_wen_q   <= '0;
      grp_ren_q   <= '0;
      grp_addr_q  <= '0;
      grp_wdata_q <= '0;
      rdata_q     <= '0;
      status_q    <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      rem_q       <= rem_d;
      wcnt_q      <= wcnt_d;
      grp_wen_q   <= grp_wen_d;
      grp_ren_q   <= grp_ren_d;
      grp_addr_q  <= grp_addr_d;
      grp_wdata_q <= grp_wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      ready_q     <= ready_d;
    end
  end

  assign grp_wen       = grp_wen_q;
  assign grp_ren       = grp_ren_q;
  assign grp_addr      = grp_addr_q;
  assign grp_wdata     = grp_wdata_q;
  assign static_rdata  = rdata_q;
  assign static_status = status_q;
  assign static_ready  = ready_q;

endmodule

// File: tb/tb_scan_group_bridge.sv
// Scoreboard bench for scan_group_bridge (three groups, default widths).
// Stimulus pushes expected strobes and completion results into queues; a
// monitor pops and compares on each strobe start and each static_ready rise.
module tb_scan_group_bridge;
  import scan_bridge_pkg::*;

  localparam int unsigned NG = 3;

  typedef struct packed {
    logic        wr;
    logic [1:0]  grp;
    logic [19:0] addr;
    logic [31:0] data;
  } strobe_t;

  typedef struct packed {
    logic        chk_rd;
    logic [31:0] rdata;
    logic [2:0]  status;
  } result_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    scan_id = '0;
  logic          static_wen = 1'b0;
  logic          static_ren = 1'b0;
  logic [19:0]   static_addr = '0;
  logic [31:0]   static_wdata = '0;
  logic [15:0]   static_fill_cnt = '0;
  logic [31:0]   static_rdata;
  logic          static_ready;
  logic [2:0]    static_status;
  logic [NG-1:0] grp_wen;
  logic [NG-1:0] grp_ren;
  logic [19:0]   grp_addr;
  logic [31:0]   grp_wdata;
  logic [NG*32-1:0] grp_rdata;
  logic [NG-1:0] grp_ready = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int starts   = 0;
  int dly [NG] = '{0, 0, 0};
  int scnt [NG] = '{0, 0, 0};

  strobe_t exp_q[$];
  result_t res_q[$];

  scan_group_bridge #(.N_GROUPS(NG)) dut (
    .clk             (clk),
    .rst             (rst),
    .scan_id         (scan_id),
    .static_wen      (static_wen),
    .static_ren      (static_ren),
    .static_addr     (static_addr),
    .static_wdata    (static_wdata),
    .static_fill_cnt (static_fill_cnt),
    .static_rdata    (static_rdata),
    .static_ready    (static_ready),
    .static_status   (static_status),
    .grp_wen         (grp_wen),
    .grp_ren         (grp_ren),
    .grp_addr        (grp_addr),
    .grp_wdata       (grp_wdata),
    .grp_rdata       (grp_rdata),
    .grp_ready       (grp_ready)
  );

  always #5 clk = ~clk;

  assign grp_rdata = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic strobe_t mk_strobe(logic wr, logic [1:0] g, logic [19:0] a, logic [31:0] d);
    strobe_t s;
    s.wr = wr; s.grp = g; s.addr = a; s.data = d;
    return s;
  endfunction

  function automatic result_t mk_result(logic chk_rd, logic [31:0] rd, logic [2:0] st);
    result_t r;
    r.chk_rd = chk_rd; r.rdata = rd; r.status = st;
    return r;
  endfunction

  // Group ready model: 0 = tied high, <0 = never, k = high after k strobe cycles
  always @(negedge clk) begin
    for (int g = 0; g < int'(NG); g++) begin
      if (dly[g] == 0) grp_ready[g] = 1'b1;
      else if (dly[g] < 0) grp_ready[g] = 1'b0;
      else if (grp_wen[g] || grp_ren[g]) begin
        scnt[g]++;
        grp_ready[g] = (scnt[g] >= dly[g]);
      end else begin
        scnt[g] = 0;
        grp_ready[g] = 1'b0;
      end
    end
  end

  // Monitor: compare strobe starts and completions against the queues
  logic any_prev = 1'b0;
  logic rdy_prev = 1'b1;
  always @(negedge clk) begin
    logic    any_now;
    strobe_t act_s, exp_s;
    result_t exp_r;
    any_now = |{grp_wen, grp_ren};
    if (!rst) begin
      if (any_now && !any_prev) begin
        starts++;
        check("strobe_onehot", 64'($onehot({grp_wen, grp_ren})), 64'd1);
        act_s.wr   = |grp_wen;
        act_s.grp  = '0;
        for (int g = 0; g < int'(NG); g++)
          if (grp_wen[g] || grp_ren[g]) act_s.grp = 2'(g);
        act_s.addr = grp_addr;
        act_s.data = grp_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'(act_s), 64'h0);
        end else begin
          exp_s = exp_q.pop_front();
          check("strobe", 64'(act_s), 64'(exp_s));
        end
      end
      if (static_ready && !rdy_prev) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 64'(static_status), 64'h0);
        end else begin
          exp_r = res_q.pop_front();
          check("done_status", 64'(static_status), 64'(exp_r.status));
          if (exp_r.chk_rd) check("done_rdata", 64'(static_rdata), 64'(exp_r.rdata));
        end
      end
    end
    any_prev = any_now;
    rdy_prev = static_ready;
  end

  task automatic start_req(input logic wr, input logic rd, input logic [1:0] id,
                           input logic [19:0] a, input logic [31:0] d, input logic [15:0] cnt);
    @(negedge clk);
    scan_id         = id;
    static_addr     = a;
    static_wdata    = d;
    static_fill_cnt = cnt;
    static_wen      = wr;
    static_ren      = rd;
  endtask

  task automatic finish_req(input string name);
    int n;
    n = 0;
    while (!static_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!static_ready) check({name, "_ready_timeout"}, 64'(static_ready), 64'd1);
    @(negedge clk);
    static_wen = 1'b0;
    static_ren = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int n;
    int base;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(static_ready),  64'd1);
    check("rst_status", 64'(static_status), 64'd0);
    check("rst_rdata",  64'(static_rdata),  64'd0);
    check("rst_wen",    64'(grp_wen),       64'd0);
    check("rst_ren",    64'(grp_ren),       64'd0);
    check("rst_addr",   64'(grp_addr),      64'd0);
    check("rst_wdata",  64'(grp_wdata),     64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Read from group 1, ready two cycles after the strobe; also latency
    dly[1] = 2;
    exp_q.push_back(mk_strobe(1'b0, 2'd1, 20'h00010, 32'h0));
    res_q.push_back(mk_result(1'b1, 32'hDEAD_BEEF, 3'b000));
    start_req(1'b0, 1'b1, 2'd1, 20'h00010, 32'h0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("lat_no_strobe_yet", 64'(grp_ren), 64'd0);
    check("lat_ready_low",     64'(static_ready), 64'd0);
    @(posedge clk);
    #1;
    check("lat_strobe", 64'(grp_ren), 64'b010);
    finish_req("read");
    check("read_rdata",  64'(static_rdata),  64'hDEAD_BEEF);
    check("read_status", 64'(static_status), 64'd0);

    // Fill of four words wrapping the address space; later input changes ignored
    dly[0] = 0;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk_strobe(1'b1, 2'd0, 20'(20'hFFFFE + i), 32'hA5A5_A5A5));
    res_q.push_back(mk_result(1'b0, 32'h0, 3'b000));
    start_req(1'b1, 1'b0, 2'd0, 20'hFFFFE, 32'hA5A5_A5A5, 16'd4);
    repeat (4) @(negedge clk);
    static_addr     = 20'h55555;
    static_wdata    = 32'h0;
    static_fill_cnt = 16'd1;
    scan_id         = 2'd2;
    finish_req("fill");

    // Timeout on group 2
    dly[2] = -1;
    exp_q.push_back(mk_strobe(1'b1, 2'd2, 20'h12345, 32'h0BAD_F00D));
    res_q.push_back(mk_result(1'b0, 32'h0, 3'b001));
    start_req(1'b1, 1'b0, 2'd2, 20'h12345, 32'h0BAD_F00D, 16'd0);
    n = 0;
    while (!grp_wen[2] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    n = 0;
    while (grp_wen[2] && n < 400) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("timeout_strobe_cycles", 64'(n), 64'd255);
    finish_req("timeout");
    check("timeout_status", 64'(static_status), 64'b001);
    check("timeout_ready",  64'(static_ready),  64'd1);

    // Invalid group id: no strobe, err_id
    start_req(1'b1, 1'b0, 2'd3, 20'h00001, 32'h1, 16'd0);
    repeat (8) @(negedge clk);
    check("badid_status", 64'(static_status), 64'b100);
    check("badid_ready",  64'(static_ready),  64'd1);
    static_wen = 1'b0;
    repeat (6) @(negedge clk);

    // Following valid read clears status
    exp_q.push_back(mk_strobe(1'b0, 2'd0, 20'h00ABC, 32'h0));
    res_q.push_back(mk_result(1'b1, 32'h1111_1111, 3'b000));
    start_req(1'b0, 1'b1, 2'd0, 20'h00ABC, 32'h0, 16'd0);
    finish_req("clear");
    check("clear_status", 64'(static_status), 64'd0);

    // Conflict: both levels rise together
    start_req(1'b1, 1'b1, 2'd1, 20'h00002, 32'h2, 16'd0);
    repeat (8) @(negedge clk);
    check("conflict_status", 64'(static_status), 64'b010);
    check("conflict_ready",  64'(static_ready),  64'd1);
    static_wen = 1'b0;
    static_ren = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during word 2 of an 8-word fill, wen held high afterwards
    exp_q.push_back(mk_strobe(1'b1, 2'd0, 20'h00100, 32'h5A5A_0000));
    exp_q.push_back(mk_strobe(1'b1, 2'd0, 20'h00101, 32'h5A5A_0000));
    base = starts;
    start_req(1'b1, 1'b0, 2'd0, 20'h00100, 32'h5A5A_0000, 16'd8);
    n = 0;
    while (starts < base + 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rstfill_two_words", 64'(starts - base), 64'd2);
    rst = 1'b1;
    #1;
    check("rstfill_wen_low",  64'(grp_wen),      64'd0);
    check("rstfill_ren_low",  64'(grp_ren),      64'd0);
    check("rstfill_ready",    64'(static_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rstfill_no_more_strobes", 64'(starts - base), 64'd2);
    check("rstfill_status", 64'(static_status), 64'd0);
    check("rstfill_idle_ready", 64'(static_ready), 64'd1);
    static_wen = 1'b0;
    repeat (4) @(negedge clk);

    check("strobe_queue_empty", 64'(exp_q.size()), 64'd0);
    check("result_queue_empty", 64'(res_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
